// File: rtl/adc_mon_pkg.sv
// Shared constants and FSM encoding for the ADC telemetry monitor.
package adc_mon_pkg;

    localparam int N_CH  = 6;
    localparam int ADC_W = 12;

    localparam int CH_REV = 0;
    localparam int CH_FWD = 4;
    localparam int CH_SUP = 5;

    localparam int CAUSE_REV = 0;
    localparam int CAUSE_UV  = 1;
    localparam int CAUSE_OV  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DONE  = 2'd2,
        ST_CHECK = 2'd3
    } mon_state_t;

endpackage

// File: rtl/adc_mon_trip.sv
// PA-protection trip latch with sticky cause flags and a saturating
// count of violation-free averaging periods that gates clear_trip.
module adc_mon_trip
    import adc_mon_pkg::*;
#(
    parameter int HOLD_PERIODS = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       check,
    input  logic       viol_rev,
    input  logic       viol_uv,
    input  logic       viol_ov,
    input  logic       clear_trip,
    output logic       trip,
    output logic [2:0] trip_cause
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_PERIODS);

    logic [7:0] hold_cnt;
    logic [2:0] viol;

    always_comb begin
        viol            = '0;
        viol[CAUSE_REV] = viol_rev;
        viol[CAUSE_UV]  = viol_uv;
        viol[CAUSE_OV]  = viol_ov;
    end

    // A check cycle never honours clear_trip, so a violation always wins.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            trip       <= 1'b0;
            trip_cause <= '0;
            hold_cnt   <= '0;
        end else if (check) begin
            if (|viol) begin
                trip       <= 1'b1;
                trip_cause <= trip_cause | viol;
                hold_cnt   <= '0;
            end else if (hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end else if (clear_trip && hold_cnt == HOLD_LAST) begin
            trip       <= 1'b0;
            trip_cause <= '0;
        end
    end

endmodule

// File: rtl/adc_monitor.sv
// Snapshots six ADC channels per sample tick, boxcar-averages them over
// 2^AVG_LOG2 samples and checks reverse power / supply against limits.
//
//   state    | meaning
//   ST_IDLE  | wait for sample tick, capture all six inputs on it
//   ST_ACC   | add one snapshot channel per cycle into its sum
//   ST_DONE  | publish averages, clear sums, pulse avg_valid
//   ST_CHECK | compare fresh averages against limits
module adc_monitor
    import adc_mon_pkg::*;
#(
    parameter int CLK_DIVIDE   = 2048,
    parameter int AVG_LOG2     = 4,
    parameter int HOLD_PERIODS = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [ADC_W-1:0] ain1,
    input  logic [ADC_W-1:0] ain2,
    input  logic [ADC_W-1:0] ain3,
    input  logic [ADC_W-1:0] ain4,
    input  logic [ADC_W-1:0] ain5,
    input  logic [ADC_W-1:0] ain6,
    input  logic [ADC_W-1:0] rev_limit,
    input  logic [ADC_W-1:0] vsup_min,
    input  logic [ADC_W-1:0] vsup_max,
    input  logic             clear_trip,
    output logic [ADC_W-1:0] avg1,
    output logic [ADC_W-1:0] avg2,
    output logic [ADC_W-1:0] avg3,
    output logic [ADC_W-1:0] avg4,
    output logic [ADC_W-1:0] avg5,
    output logic [ADC_W-1:0] avg6,
    output logic             avg_valid,
    output logic             trip,
    output logic [2:0]       trip_cause
);

    localparam int                 SUM_W    = ADC_W + AVG_LOG2;
    localparam int                 DIV_W    = 16;
    localparam logic [DIV_W-1:0]   DIV_LAST = 16'(CLK_DIVIDE - 1);
    localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

    mon_state_t state, state_nxt;

    logic [DIV_W-1:0]    div;
    logic                tick;
    logic [2:0]          ch;
    logic                last_ch;
    logic [AVG_LOG2-1:0] sample_cnt;
    logic [ADC_W-1:0]    ain_v [N_CH];
    logic [ADC_W-1:0]    snap  [N_CH];
    logic [SUM_W-1:0]    sum   [N_CH];
    logic [ADC_W-1:0]    avg_r [N_CH];

    logic snap_load, acc_en, done_en, check_en;

    assign ain_v[0] = ain1;
    assign ain_v[1] = ain2;
    assign ain_v[2] = ain3;
    assign ain_v[3] = ain4;
    assign ain_v[4] = ain5;
    assign ain_v[5] = ain6;

    assign tick    = (div == DIV_LAST);
    assign last_ch = (ch == 3'(N_CH - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Ticks seen outside IDLE are simply dropped.
    always_comb begin
        state_nxt = state;
        snap_load = 1'b0;
        acc_en    = 1'b0;
        done_en   = 1'b0;
        check_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    snap_load = 1'b1;
                    state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                acc_en = 1'b1;
                if (last_ch)
                    state_nxt = (sample_cnt == CNT_LAST) ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                done_en   = 1'b1;
                state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                check_en  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            div        <= '0;
            ch         <= '0;
            sample_cnt <= '0;
            avg_valid  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                snap[i]  <= '0;
                sum[i]   <= '0;
                avg_r[i] <= '0;
            end
        end else begin
            div       <= tick ? '0 : div + 16'd1;
            avg_valid <= done_en;

            if (snap_load) begin
                ch <= '0;
                for (int i = 0; i < N_CH; i++) snap[i] <= ain_v[i];
            end

            if (acc_en) begin
                ch <= last_ch ? 3'd0 : ch + 3'd1;
                for (int i = 0; i < N_CH; i++)
                    if (ch == 3'(i))
                        sum[i] <= sum[i] + {{AVG_LOG2{1'b0}}, snap[i]};
                if (last_ch && sample_cnt != CNT_LAST)
                    sample_cnt <= sample_cnt + 1'b1;
            end

            if (done_en) begin
                sample_cnt <= '0;
                for (int i = 0; i < N_CH; i++) begin
                    avg_r[i] <= ADC_W'(sum[i] >> AVG_LOG2);
                    sum[i]   <= '0;
                end
            end
        end
    end

    assign avg1 = avg_r[0];
    assign avg2 = avg_r[1];
    assign avg3 = avg_r[2];
    assign avg4 = avg_r[3];
    assign avg5 = avg_r[4];
    assign avg6 = avg_r[5];

    adc_mon_trip #(
        .HOLD_PERIODS (HOLD_PERIODS)
    ) u_trip (
        .clock      (clock),
        .reset_n    (reset_n),
        .check      (check_en),
        .viol_rev   (avg_r[CH_REV] > rev_limit),
        .viol_uv    (avg_r[CH_SUP] < vsup_min),
        .viol_ov    (avg_r[CH_SUP] > vsup_max),
        .clear_trip (clear_trip),
        .trip       (trip),
        .trip_cause (trip_cause)
    );

endmodule

// File: tb/tb_adc_monitor.sv
// Directed bench for adc_monitor: per-period vector table plus hand
// sequences for reset-during-accumulation and a 256-sample average.
module tb_adc_monitor;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rst8 = 1'b0;
    logic [11:0] ain1, ain2, ain3, ain4, ain5, ain6;
    logic [11:0] rev_limit, vsup_min, vsup_max;
    logic        clear_trip = 1'b0;
    logic [11:0] avg1, avg2, avg3, avg4, avg5, avg6;
    logic        avg_valid, trip;
    logic [2:0]  trip_cause;

    logic [11:0] full = 12'd4095;
    logic [11:0] zero = 12'd0;
    logic        no_clr = 1'b0;
    logic [11:0] b1, b2, b3, b4, b5, b6;
    logic        avg_valid8, trip8;
    logic [2:0]  trip_cause8;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    adc_monitor #(.CLK_DIVIDE(16), .AVG_LOG2(2), .HOLD_PERIODS(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .ain1(ain1), .ain2(ain2), .ain3(ain3), .ain4(ain4), .ain5(ain5), .ain6(ain6),
        .rev_limit(rev_limit), .vsup_min(vsup_min), .vsup_max(vsup_max),
        .clear_trip(clear_trip),
        .avg1(avg1), .avg2(avg2), .avg3(avg3), .avg4(avg4), .avg5(avg5), .avg6(avg6),
        .avg_valid(avg_valid), .trip(trip), .trip_cause(trip_cause)
    );

    adc_monitor #(.CLK_DIVIDE(16), .AVG_LOG2(8), .HOLD_PERIODS(2)) dut8 (
        .clock(clock), .reset_n(rst8),
        .ain1(full), .ain2(full), .ain3(full), .ain4(full), .ain5(full), .ain6(full),
        .rev_limit(full), .vsup_min(zero), .vsup_max(full),
        .clear_trip(no_clr),
        .avg1(b1), .avg2(b2), .avg3(b3), .avg4(b4), .avg5(b5), .avg6(b6),
        .avg_valid(avg_valid8), .trip(trip8), .trip_cause(trip_cause8)
    );

    typedef struct {
        logic [5:0][11:0] a;
        logic [11:0]      a2_late;
        logic [11:0]      rev, vmin, vmax;
        logic             clr_chk, clr_after;
        logic [5:0][11:0] e_avg;
        logic             e_trip;
        logic [2:0]       e_cause;
        logic             e_trip_clr;
        logic [2:0]       e_cause_clr;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [5:0][11:0] ch6(input int v1, v2, v3, v4, v5, v6);
        logic [5:0][11:0] r;
        r[0] = 12'(v1); r[1] = 12'(v2); r[2] = 12'(v3);
        r[3] = 12'(v4); r[4] = 12'(v5); r[5] = 12'(v6);
        return r;
    endfunction

    function automatic vec_t mk(input logic [5:0][11:0] a, input int late, rev, vmin, vmax,
                                input logic cc, ca, input logic [5:0][11:0] e,
                                input logic et, input logic [2:0] ec,
                                input logic etc_, input logic [2:0] ecc);
        vec_t v;
        v.a = a; v.a2_late = 12'(late);
        v.rev = 12'(rev); v.vmin = 12'(vmin); v.vmax = 12'(vmax);
        v.clr_chk = cc; v.clr_after = ca; v.e_avg = e;
        v.e_trip = et; v.e_cause = ec; v.e_trip_clr = etc_; v.e_cause_clr = ecc;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_ain(input logic [5:0][11:0] a);
        ain1 = a[0]; ain2 = a[1]; ain3 = a[2];
        ain4 = a[3]; ain5 = a[4]; ain6 = a[5];
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!avg_valid && n < 200);
        if (!avg_valid) begin
            n_vec++;
            n_bad++;
            $display("FAIL avg_valid_timeout: got no pulse in %0d cycles, expected one", n);
        end
    endtask

    task automatic chk_avgs(input string tag, input logic [5:0][11:0] e);
        chk({tag, ".avg1"}, avg1, e[0]);
        chk({tag, ".avg2"}, avg2, e[1]);
        chk({tag, ".avg3"}, avg3, e[2]);
        chk({tag, ".avg4"}, avg4, e[3]);
        chk({tag, ".avg5"}, avg5, e[4]);
        chk({tag, ".avg6"}, avg6, e[5]);
    endtask

    initial begin
        logic [5:0][11:0] base, allf, sup_ok, y;
        int n;

        base   = ch6(100, 200, 300, 400, 500, 600);
        allf   = ch6(4095, 4095, 4095, 4095, 4095, 4095);
        sup_ok = ch6(100, 200, 300, 400, 500, 1000);

        vecs[0]  = mk(base, 200, 4095, 0, 4095, 0, 0, base, 0, 3'b000, 0, 3'b000);
        vecs[1]  = mk(allf, 4095, 4095, 0, 4095, 0, 0, allf, 0, 3'b000, 0, 3'b000);
        vecs[2]  = mk(ch6(100, 1, 300, 400, 500, 600), 2, 4095, 0, 4095, 0, 0,
                      ch6(100, 1, 300, 400, 500, 600), 0, 3'b000, 0, 3'b000);
        vecs[3]  = mk(ch6(3000, 200, 300, 400, 500, 600), 200, 2000, 0, 4095, 0, 0,
                      ch6(3000, 200, 300, 400, 500, 600), 1, 3'b001, 1, 3'b001);
        vecs[4]  = mk(base, 200, 2000, 0, 4095, 0, 1, base, 1, 3'b001, 1, 3'b001);
        vecs[5]  = mk(base, 200, 2000, 0, 4095, 0, 1, base, 1, 3'b001, 0, 3'b000);
        vecs[6]  = mk(ch6(100, 200, 300, 400, 500, 500), 200, 2000, 800, 3500, 0, 0,
                      ch6(100, 200, 300, 400, 500, 500), 1, 3'b010, 1, 3'b010);
        vecs[7]  = mk(sup_ok, 200, 2000, 800, 3500, 0, 0, sup_ok, 1, 3'b010, 1, 3'b010);
        vecs[8]  = mk(sup_ok, 200, 2000, 800, 3500, 0, 1, sup_ok, 1, 3'b010, 0, 3'b000);
        vecs[9]  = mk(ch6(100, 200, 300, 400, 500, 3800), 200, 2000, 800, 3500, 0, 0,
                      ch6(100, 200, 300, 400, 500, 3800), 1, 3'b100, 1, 3'b100);
        vecs[10] = mk(ch6(100, 200, 300, 400, 500, 500), 200, 2000, 800, 3500, 0, 0,
                      ch6(100, 200, 300, 400, 500, 500), 1, 3'b110, 1, 3'b110);
        vecs[11] = mk(ch6(3000, 200, 300, 400, 500, 500), 200, 2000, 800, 3500, 0, 0,
                      ch6(3000, 200, 300, 400, 500, 500), 1, 3'b111, 1, 3'b111);
        vecs[12] = mk(sup_ok, 200, 2000, 800, 3500, 0, 0, sup_ok, 1, 3'b111, 1, 3'b111);
        vecs[13] = mk(sup_ok, 200, 2000, 800, 3500, 0, 1, sup_ok, 1, 3'b111, 0, 3'b000);
        vecs[14] = mk(ch6(100, 200, 300, 400, 500, 500), 200, 2000, 800, 3500, 1, 0,
                      ch6(100, 200, 300, 400, 500, 500), 1, 3'b010, 1, 3'b010);

        set_ain(base);
        rev_limit = 12'd4095; vsup_min = 12'd0; vsup_max = 12'd4095;
        repeat (3) @(negedge clock);
        chk_avgs("reset", ch6(0, 0, 0, 0, 0, 0));
        chk("reset.avg_valid", avg_valid, 0);
        chk("reset.trip", trip, 0);
        chk("reset.cause", trip_cause, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            set_ain(vecs[i].a);
            rev_limit = vecs[i].rev; vsup_min = vecs[i].vmin; vsup_max = vecs[i].vmax;
            if (vecs[i].a2_late != vecs[i].a[1]) begin
                repeat (40) @(negedge clock);
                ain2 = vecs[i].a2_late;
            end
            wait_valid(n);
            if (i == 0) chk("first_valid_latency", n, 71);
            chk_avgs(tag, vecs[i].e_avg);
            if (vecs[i].clr_chk) clear_trip = 1'b1;
            @(negedge clock);
            clear_trip = 1'b0;
            chk({tag, ".valid_width"}, avg_valid, 0);
            chk({tag, ".trip"}, trip, vecs[i].e_trip);
            chk({tag, ".cause"}, trip_cause, vecs[i].e_cause);
            if (vecs[i].clr_after) begin
                clear_trip = 1'b1;
                @(negedge clock);
                clear_trip = 1'b0;
                chk({tag, ".clr_trip"}, trip, vecs[i].e_trip_clr);
                chk({tag, ".clr_cause"}, trip_cause, vecs[i].e_cause_clr);
            end
        end

        // Reset while the third sample of a period is at channel 3.
        wait_valid(n);
        set_ain(ch6(1000, 1000, 1000, 1000, 1000, 1000));
        repeat (44) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        y = ch6(7, 77, 777, 1777, 2777, 3777);
        set_ain(y);
        rev_limit = 12'd4095; vsup_min = 12'd0; vsup_max = 12'd4095;
        chk_avgs("midreset", ch6(0, 0, 0, 0, 0, 0));
        chk("midreset.avg_valid", avg_valid, 0);
        chk("midreset.trip", trip, 0);
        chk("midreset.cause", trip_cause, 0);
        wait_valid(n);
        chk("midreset.latency", n, 71);
        chk_avgs("postreset", y);
        @(negedge clock);
        chk("postreset.trip", trip, 0);

        // 256-sample average of full-scale inputs.
        rst8 = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!avg_valid8 && n < 4300);
        chk("avg8.latency", n, 4103);
        chk("avg8.avg1", b1, 4095);
        chk("avg8.avg2", b2, 4095);
        chk("avg8.avg3", b3, 4095);
        chk("avg8.avg4", b4, 4095);
        chk("avg8.avg5", b5, 4095);
        chk("avg8.avg6", b6, 4095);
        @(negedge clock);
        chk("avg8.valid_width", avg_valid8, 0);
        chk("avg8.trip", trip8, 0);
        chk("avg8.cause", trip_cause8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
